// File: rtl/temp_ascii_formatter_if.sv
// temp_ascii_formatter_if: start/temperature request plus UART byte handshake bundle
// master: requester and UART side (drives start_i, temp_i, tx_ready_i)
// slave : formatter side (drives busy_o, tx_data_o, tx_valid_o, done_o)
interface temp_ascii_formatter_if;
  logic        start_i;
  logic [12:0] temp_i;
  logic        busy_o;
  logic [7:0]  tx_data_o;
  logic        tx_valid_o;
  logic        tx_ready_i;
  logic        done_o;
  modport master(output start_i, temp_i, tx_ready_i, input busy_o, tx_data_o, tx_valid_o, done_o);
  modport slave(input start_i, temp_i, tx_ready_i, output busy_o, tx_data_o, tx_valid_o, done_o);
endinterface

// File: rtl/temp_ascii_formatter.sv
// temp_ascii_formatter: turns a 13-bit ADT7420 reading into an ASCII frame "+ddd.dC[\r\n]" for a UART
// clk_i  : rising-edge clock
// rst_ni : asynchronous active-low reset
// bus    : slave side of temp_ascii_formatter_if (start/temp request, busy/done, tx byte handshake)
module temp_ascii_formatter #(
  parameter bit SEND_CRLF = 1'b1
) (
  input  logic clk_i,
  input  logic rst_ni,
  temp_ascii_formatter_if.slave bus
);
  typedef enum logic [2:0] {IDLE, ABS, CONV, EMIT, DONE} state_t;
  localparam logic [3:0] LAST = SEND_CRLF ? 4'd8 : 4'd6;
  state_t      r_state;
  logic [12:0] r_temp;
  logic [8:0]  r_int;
  logic [3:0]  r_tenths;
  logic [11:0] r_bcd;
  logic [3:0]  r_cnt;
  logic [12:0] w_mag;
  logic [3:0]  w_tenths;
  logic [11:0] w_adj;
  function automatic logic [3:0] f_adj(input logic [3:0] n);
    return n >= 4'd5 ? n + 4'd3 : n;
  endfunction
  function automatic logic [7:0] f_byte(input logic [3:0] idx);
    case (idx)
      4'd0:    return r_temp[12] ? 8'h2D : 8'h2B;
      4'd1:    return {4'h3, r_bcd[11:8]};
      4'd2:    return {4'h3, r_bcd[7:4]};
      4'd3:    return {4'h3, r_bcd[3:0]};
      4'd4:    return 8'h2E;
      4'd5:    return {4'h3, r_tenths};
      4'd6:    return 8'h43;
      4'd7:    return 8'h0D;
      default: return 8'h0A;
    endcase
  endfunction
  // -(-4096) wraps back to 0x1000 in 13 bits, which is exactly the magnitude 4096 we want
  assign w_mag    = r_temp[12] ? -r_temp : r_temp;
  assign w_tenths = 4'(({4'd0, w_mag[3:0]} * 8'd10) >> 4);
  assign w_adj    = {f_adj(r_bcd[11:8]), f_adj(r_bcd[7:4]), f_adj(r_bcd[3:0])};
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state        <= IDLE;
      r_temp         <= '0;
      r_int          <= '0;
      r_tenths       <= '0;
      r_bcd          <= '0;
      r_cnt          <= '0;
      bus.busy_o     <= 1'b0;
      bus.tx_data_o  <= 8'h00;
      bus.tx_valid_o <= 1'b0;
      bus.done_o     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (bus.start_i) begin
          r_temp     <= bus.temp_i;
          bus.busy_o <= 1'b1;
          r_state    <= ABS;
        end
        ABS: begin
          r_int    <= w_mag[12:4];
          r_tenths <= w_tenths;
          r_bcd    <= '0;
          r_cnt    <= '0;
          r_state  <= CONV;
        end
        CONV: begin
          // adjusted BCD shifted left with the next integer bit (MSB first); top carry is never set for <=256
          r_bcd <= 12'({w_adj, r_int[8]});
          r_int <= r_int << 1;
          r_cnt <= r_cnt + 4'd1;
          if (r_cnt == 4'd8) begin
            r_cnt          <= '0;
            r_state        <= EMIT;
            bus.tx_valid_o <= 1'b1;
            bus.tx_data_o  <= r_temp[12] ? 8'h2D : 8'h2B;
          end
        end
        EMIT: if (bus.tx_ready_i) begin
          if (r_cnt == LAST) begin
            bus.tx_valid_o <= 1'b0;
            bus.done_o     <= 1'b1;
            r_state        <= DONE;
          end else begin
            r_cnt         <= r_cnt + 4'd1;
            bus.tx_data_o <= f_byte(r_cnt + 4'd1);
          end
        end
        DONE: begin
          bus.done_o <= 1'b0;
          bus.busy_o <= 1'b0;
          r_state    <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_temp_ascii_formatter.sv
// tb_temp_ascii_formatter: random and directed frames on CRLF and non-CRLF formatters against an arithmetic model
module tb_temp_ascii_formatter;
  typedef logic [7:0] bq_t[$];
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [12:0] temp = '0;
  logic        rdy [2];
  int          n_cmp = 0;
  int          n_err = 0;
  always #5 clk = ~clk;
  temp_ascii_formatter_if if9();
  temp_ascii_formatter_if if7();
  temp_ascii_formatter #(.SEND_CRLF(1'b1)) dut9(.clk_i(clk), .rst_ni(rst_n), .bus(if9));
  temp_ascii_formatter #(.SEND_CRLF(1'b0)) dut7(.clk_i(clk), .rst_ni(rst_n), .bus(if7));
  assign if9.start_i    = start;
  assign if9.temp_i     = temp;
  assign if9.tx_ready_i = rdy[0];
  assign if7.start_i    = start;
  assign if7.temp_i     = temp;
  assign if7.tx_ready_i = rdy[1];
  function automatic logic f_vld(int d);
    return d == 0 ? if9.tx_valid_o : if7.tx_valid_o;
  endfunction
  function automatic logic [7:0] f_dat(int d);
    return d == 0 ? if9.tx_data_o : if7.tx_data_o;
  endfunction
  function automatic logic f_busy(int d);
    return d == 0 ? if9.busy_o : if7.busy_o;
  endfunction
  function automatic logic f_done(int d);
    return d == 0 ? if9.done_o : if7.done_o;
  endfunction
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic bq_t model(input logic [12:0] t, input bit crlf);
    bq_t q;
    int v  = t[12] ? int'(t) - 8192 : int'(t);
    int m  = v < 0 ? -v : v;
    int ip = m / 16;
    int tn = (m % 16) * 10 / 16;
    q = {v < 0 ? 8'h2D : 8'h2B, 8'(48 + ip / 100), 8'(48 + (ip / 10) % 10), 8'(48 + ip % 10),
         8'h2E, 8'(48 + tn), 8'h43};
    if (crlf) begin
      q.push_back(8'h0D);
      q.push_back(8'h0A);
    end
    return q;
  endfunction
  task automatic run_frame(input logic [12:0] t, input int sb, input int sl, input bit noise);
    bq_t  exp [2];
    bq_t  got [2];
    int   first [2], dn_n [2], dn_cnt [2], stalls [2];
    bit   pv [2], pr [2];
    logic [7:0] pd [2];
    bit   ok = 1'b0;
    exp[0] = model(t, 1'b1);
    exp[1] = model(t, 1'b0);
    for (int d = 0; d < 2; d++) begin
      first[d] = -1; dn_n[d] = -1; dn_cnt[d] = 0; stalls[d] = 0; pv[d] = 0; pr[d] = 1; pd[d] = '0;
      rdy[d] = 1'b1;
    end
    @(negedge clk);
    start = 1'b1;
    temp  = t;
    @(negedge clk);
    for (int n = 0; n < 300; n++) begin
      start = noise && (n == 3 || n == 12);
      temp  = start ? t ^ 13'h1555 : t;
      for (int d = 0; d < 2; d++) begin
        if (n == 0) check("busy_set", 32'(f_busy(d)), 32'd1);
        if (pv[d] && !pr[d]) check("hold", {23'd0, f_vld(d), f_dat(d)}, {23'd0, 1'b1, pd[d]});
        if (f_vld(d) && first[d] < 0) first[d] = n;
        if (f_done(d)) begin
          dn_cnt[d]++;
          if (dn_n[d] < 0) dn_n[d] = n;
        end
        rdy[d] = !(f_vld(d) && got[d].size() == sb && stalls[d] < sl);
        if (!rdy[d]) stalls[d]++;
        if (f_vld(d) && rdy[d]) got[d].push_back(f_dat(d));
        pv[d] = f_vld(d);
        pr[d] = rdy[d];
        pd[d] = f_dat(d);
      end
      if (dn_n[0] >= 0 && dn_n[1] >= 0) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    start = 1'b0;
    if (!ok) check("timeout", 32'd0, 32'd1);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      if (f_done(d)) dn_cnt[d]++;
      check("busy_clear", 32'(f_busy(d)), 32'd0);
      check("first_valid", 32'(first[d]), 32'd10);
      check("done_pulses", 32'(dn_cnt[d]), 32'd1);
      check("nbytes", 32'(got[d].size()), 32'(exp[d].size()));
      for (int i = 0; i < exp[d].size(); i++)
        check($sformatf("byte%0d_%s_t%0h", i, d == 0 ? "crlf" : "nocrlf", t),
              i < got[d].size() ? 32'(got[d][i]) : 32'hFFFF, 32'(exp[d][i]));
    end
  endtask
  task automatic reset_mid_frame();
    @(negedge clk);
    start = 1'b1;
    temp  = 13'h0190;
    rdy[0] = 1'b1;
    rdy[1] = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    check("pre_rst_byte5", 32'(f_dat(0)), 32'h2E);
    rst_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++)
      check("async_rst", {28'd0, f_vld(d), f_busy(d), f_done(d), 1'b0} | 32'(f_dat(d)), 32'd0);
    repeat (3) @(negedge clk);
    check("rst_no_bytes", {30'd0, f_vld(0), f_vld(1)}, 32'd0);
    rst_n = 1'b1;
    run_frame(13'h0190, 99, 0, 1'b0);
  endtask
  initial begin
    rdy[0] = 1'b1;
    rdy[1] = 1'b1;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++)
      check("reset_state", {23'd0, f_vld(d), f_dat(d)} | {30'd0, f_busy(d), f_done(d)}, 32'd0);
    rst_n = 1'b1;
    run_frame(13'h0190, 99, 0, 1'b0);
    run_frame(13'h1F58, 99, 0, 1'b0);
    run_frame(13'h0FFF, 99, 0, 1'b0);
    run_frame(13'h1000, 99, 0, 1'b0);
    run_frame(13'h0000, 99, 0, 1'b0);
    run_frame(13'h0190, 2, 5, 1'b0);
    run_frame(13'h0190, 99, 0, 1'b1);
    reset_mid_frame();
    for (int k = 0; k < 12; k++)
      run_frame(13'($urandom), $urandom_range(0, 8), $urandom_range(0, 4), 1'($urandom_range(0, 1)));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
